// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types and constants for the RISC-V core pipeline registers.
package rv_pipe_pkg;

  localparam int RV_XLEN = 64;
  localparam int RV_RD_W = 5;

  typedef struct packed {
    logic               regwrite;
    logic               memtoreg;
    logic [RV_XLEN-1:0] alures;
    logic [RV_XLEN-1:0] readmem;
    logic [RV_RD_W-1:0] rd;
  } mem_wb_t;

  // Flattened width of a MEM/WB bundle for arbitrary XLEN/RD_W.
  function automatic int mem_wb_width(int xlen, int rd_w);
    return 2 + 2 * xlen + rd_w;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_if.sv
// MEM/WB handshake bundle: MEM-side input bundle, write-back-side head bundle and flush.
interface mem_wb_pipe_if
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = RV_XLEN,
  parameter int RD_W = RV_RD_W
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            regwrite;
  logic            memtoreg;
  logic [XLEN-1:0] alures;
  logic [XLEN-1:0] readmem;
  logic [RD_W-1:0] rd;
  logic            out_valid;
  logic            out_ready;
  logic            regwriteout;
  logic            memtoregout;
  logic [XLEN-1:0] aluresout;
  logic [XLEN-1:0] readmemout;
  logic [RD_W-1:0] rdout;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;

  modport master (
    output flush, in_valid, regwrite, memtoreg, alures, readmem, rd, out_ready,
    input  in_ready, out_valid, regwriteout, memtoregout, aluresout, readmemout,
           rdout, wb_data, wb_we
  );

  modport slave (
    input  flush, in_valid, regwrite, memtoreg, alures, readmem, rd, out_ready,
    output in_ready, out_valid, regwriteout, memtoregout, aluresout, readmemout,
           rdout, wb_data, wb_we
  );

endinterface

// File: rtl/pipe_skid_slot.sv
// Generic valid+payload register slot; clear beats load, idle holds.
module pipe_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         vld,
  output logic [W-1:0] dout
);

  // Clear drops only the valid bit; the payload keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (clear) begin
      vld  <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage with valid/ready, stall, flush and write-back select.
// Define MEM_WB_SKID_EN for a registered in_ready backed by a second (skid) slot.
module mem_wb_pipe
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = RV_XLEN,
  parameter int RD_W = RV_RD_W
) (
  input logic          clk,
  input logic          reset,
  mem_wb_pipe_if.slave bus
);

  localparam int PW = mem_wb_width(XLEN, RD_W);

  logic [PW-1:0] in_pl;
  logic [PW-1:0] head_din;
  logic [PW-1:0] head_dout;
  logic          head_vld;
  logic          head_load;
  logic          head_clear;
  logic          in_xfer;
  logic          out_xfer;

  assign in_pl    = {bus.regwrite, bus.memtoreg, bus.alures, bus.readmem, bus.rd};
  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = head_vld & bus.out_ready;

`ifdef MEM_WB_SKID_EN
  logic [PW-1:0] skid_dout;
  logic          skid_vld;
  logic          skid_load;
  logic          skid_clear;

  // in_ready comes straight from the skid valid flop, so it is registered.
  assign bus.in_ready = ~skid_vld;

  // Head refills from skid first; otherwise from input when it is free or draining.
  assign head_load  = (out_xfer & skid_vld) | (in_xfer & (~head_vld | bus.out_ready));
  assign head_din   = skid_vld ? skid_dout : in_pl;
  assign head_clear = bus.flush | (out_xfer & ~head_load);

  assign skid_load  = in_xfer & head_vld & ~bus.out_ready;
  assign skid_clear = bus.flush | out_xfer;

  pipe_skid_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (in_pl),
    .vld   (skid_vld),
    .dout  (skid_dout)
  );
`else
  assign bus.in_ready = bus.out_ready | ~head_vld;
  assign head_load    = in_xfer;
  assign head_din     = in_pl;
  assign head_clear   = bus.flush | (out_xfer & ~in_xfer);
`endif

  pipe_skid_slot #(.W(PW)) u_head (
    .clk   (clk),
    .reset (reset),
    .load  (head_load),
    .clear (head_clear),
    .din   (head_din),
    .vld   (head_vld),
    .dout  (head_dout)
  );

  // Head register to write-back outputs
  assign bus.out_valid = head_vld;
  assign {bus.regwriteout, bus.memtoregout, bus.aluresout, bus.readmemout, bus.rdout} = head_dout;

  assign bus.wb_data = bus.memtoregout ? bus.readmemout : bus.aluresout;
  assign bus.wb_we   = bus.out_valid & bus.out_ready & bus.regwriteout & (bus.rdout != '0);

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed-vector bench for mem_wb_pipe; covers both builds via MEM_WB_SKID_EN.
module tb_mem_wb_pipe;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_wb_pipe_if #(.XLEN(64), .RD_W(5)) bus ();

  mem_wb_pipe #(.XLEN(64), .RD_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic [63:0] alu, input logic [63:0] mem, input logic [4:0] r);
    bus.in_valid = v;
    bus.regwrite = rw;
    bus.memtoreg = m2r;
    bus.alures   = alu;
    bus.readmem  = mem;
    bus.rd       = r;
  endtask

  logic [63:0] stream_vals [3];

  initial begin
    checks   = 0;
    failures = 0;
    stream_vals[0] = 64'h10;
    stream_vals[1] = 64'h20;
    stream_vals[2] = 64'h30;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);

    // Reset for two cycles
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_wb_we", 64'(bus.wb_we), 64'd0);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    chk("rst_aluresout", bus.aluresout, 64'd0);
    chk("rst_readmemout", bus.readmemout, 64'd0);
    chk("rst_rdout", 64'(bus.rdout), 64'd0);
    chk("rst_regwriteout", 64'(bus.regwriteout), 64'd0);
    chk("rst_memtoregout", 64'(bus.memtoregout), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Streaming 0x10, 0x20, 0x30 back to back
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, stream_vals[i], 64'hFFFF, 5'd3);
      #1;
      chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
      step();
      chk("stream_valid", 64'(bus.out_valid), 64'd1);
      chk("stream_wb_data", bus.wb_data, stream_vals[i]);
      chk("stream_wb_we", 64'(bus.wb_we), 64'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    step();
    chk("stream_drain", 64'(bus.out_valid), 64'd0);

    // Stall with head 0xAA
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 64'hAA, 64'h0, 5'd7);
    step();
    chk("stall_head", bus.aluresout, 64'hAA);
    drive(1'b1, 1'b1, 1'b0, 64'hBB, 64'h0, 5'd8);
    for (int i = 0; i < 3; i++) begin
      #1;
`ifdef MEM_WB_SKID_EN
      chk("stall_in_ready", 64'(bus.in_ready), (i == 0) ? 64'd1 : 64'd0);
`else
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
`endif
      step();
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_alures", bus.aluresout, 64'hAA);
      chk("stall_rd", 64'(bus.rdout), 64'd7);
      chk("stall_wb_we", 64'(bus.wb_we), 64'd0);
    end
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("release_first", bus.wb_data, 64'hAA);
    chk("release_we", 64'(bus.wb_we), 64'd1);
    step();
`ifdef MEM_WB_SKID_EN
    chk("release_second_valid", 64'(bus.out_valid), 64'd1);
    chk("release_second", bus.wb_data, 64'hBB);
    step();
`endif
    chk("release_drain", 64'(bus.out_valid), 64'd0);

    // Flush colliding with an in-transfer
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 64'h77, 64'h0, 5'd2);
    step();
    chk("flush_head_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 64'h55, 64'h0, 5'd4);
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    #1;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_payload_kept", bus.aluresout, 64'h77);
    step();
    chk("flush_no_55_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_no_55_data", bus.aluresout, 64'h77);

    // Write-back select and x0 suppression
    drive(1'b1, 1'b1, 1'b1, 64'h1234, 64'hDEADBEEF, 5'd5);
    step();
    chk("wb_sel_data", bus.wb_data, 64'hDEADBEEF);
    chk("wb_sel_we", 64'(bus.wb_we), 64'd1);
    chk("wb_sel_rd", 64'(bus.rdout), 64'd5);
    drive(1'b1, 1'b1, 1'b1, 64'h1234, 64'hDEADBEEF, 5'd0);
    step();
    chk("x0_valid", 64'(bus.out_valid), 64'd1);
    chk("x0_data", bus.wb_data, 64'hDEADBEEF);
    chk("x0_we", 64'(bus.wb_we), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 64'h1234, 64'hDEADBEEF, 5'd9);
    step();
    chk("alu_sel_data", bus.wb_data, 64'h1234);
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    step();
    chk("wb_drain", 64'(bus.out_valid), 64'd0);

    // Reset while a bundle is stalled
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 64'h99, 64'h0, 5'd6);
    step();
    drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 5'd0);
    chk("rststall_held", bus.aluresout, 64'h99);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("rststall_valid", 64'(bus.out_valid), 64'd0);
    chk("rststall_alures", bus.aluresout, 64'd0);
    chk("rststall_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    step();
    chk("rststall_never", 64'(bus.out_valid), 64'd0);
    chk("rststall_we", 64'(bus.wb_we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
